// File: rtl/hci_bank_arbiter_if.sv
// Requestor and bank-side bus for one TCDM bank arbiter.
// The slave view is the arbiter; the master view drives requests and the bank model.
interface hci_bank_arbiter_if #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned BW   = 8,
    parameter int unsigned IW   = 8
) ();
    logic [N_IN-1:0]         in_req_i;
    logic [N_IN-1:0]         in_gnt_o;
    logic [N_IN*AW-1:0]      in_add_i;
    logic [N_IN-1:0]         in_wen_i;
    logic [N_IN*(DW/BW)-1:0] in_be_i;
    logic [N_IN*DW-1:0]      in_data_i;
    logic [N_IN*IW-1:0]      in_id_i;
    logic [N_IN-1:0]         in_r_valid_o;
    logic [DW-1:0]           in_r_data_o;
    logic [IW-1:0]           in_r_id_o;
    logic                    mem_req_o;
    logic                    mem_gnt_i;
    logic [AW-1:0]           mem_add_o;
    logic                    mem_wen_o;
    logic [DW/BW-1:0]        mem_be_o;
    logic [DW-1:0]           mem_data_o;
    logic [DW-1:0]           mem_r_data_i;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i,
        input  in_data_i, in_id_i, mem_gnt_i, mem_r_data_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_be_o,
        output mem_data_o
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i,
        output in_data_i, in_id_i, mem_gnt_i, mem_r_data_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_be_o,
        input  mem_data_o
    );
endinterface

// File: rtl/hci_bank_arbiter.sv
// N-way per-bank arbiter with starvation escape or round-robin, and 1-cycle response routing.
// Optional statistics counters are built when HCI_BANK_ARB_STATS_EN is defined.
module hci_bank_arbiter #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned BW    = 8,
    parameter int unsigned IW    = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned RR_EN = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [CNT_W-1:0]     ctrl_max_stall_i,
    hci_bank_arbiter_if.slave    bus,
    output logic [N_IN*32-1:0]   stat_grant_o,
    output logic [31:0]          stat_conflict_o
);
    localparam int unsigned BEW   = DW / BW;
    localparam int unsigned IDX_W = $clog2(N_IN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt [N_IN];
    logic [N_IN-1:0]  starved;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] w_q;
    logic [IW-1:0]    win_id;
    logic [IW-1:0]    id_q;
    logic             r_valid_q;
    logic             any_req;
    logic             hs;

    assign any_req       = |bus.in_req_i;
    assign hs            = any_req & bus.mem_gnt_i;
    assign bus.mem_req_o = any_req;

    // A requester is starved once it has waited at least the threshold
    always_comb begin
        starved = '0;
        for (int i = 0; i < N_IN; i++) begin
            starved[i] = bus.in_req_i[i]
                       && (ctrl_max_stall_i != '0)
                       && (stall_cnt[i] >= ctrl_max_stall_i);
        end
    end

    // Winner selection: rotating search or fixed priority with escape
    always_comb begin
        logic        found;
        int unsigned c;
        win   = '0;
        found = 1'b0;
        c     = 0;
        if (RR_EN != 0) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                c = (32'(rr_ptr) + k) % N_IN;
                if (!found && bus.in_req_i[IDX_W'(c)]) begin
                    win   = IDX_W'(c);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (bus.in_req_i[i]) win = IDX_W'(i);
            end
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (starved[i]) win = IDX_W'(i);
            end
        end
    end

    // Route the winner's payload to the bank and its grant back
    always_comb begin
        bus.in_gnt_o   = '0;
        bus.mem_add_o  = '0;
        bus.mem_wen_o  = 1'b0;
        bus.mem_be_o   = '0;
        bus.mem_data_o = '0;
        win_id         = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (win == IDX_W'(i)) begin
                bus.mem_add_o  = bus.in_add_i[i*AW +: AW];
                bus.mem_wen_o  = bus.in_wen_i[i];
                bus.mem_be_o   = bus.in_be_i[i*BEW +: BEW];
                bus.mem_data_o = bus.in_data_i[i*DW +: DW];
                win_id         = bus.in_id_i[i*IW +: IW];
            end
        end
        bus.in_gnt_o[win] = hs;
    end

    // Per-channel wait counters, saturating, zeroed on grant or idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IN; i++) stall_cnt[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < N_IN; i++) stall_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.in_req_i[i] && !bus.in_gnt_o[i]) begin
                    if (stall_cnt[i] != CNT_MAX)
                        stall_cnt[i] <= stall_cnt[i] + 1'b1;
                end else begin
                    stall_cnt[i] <= '0;
                end
            end
        end
    end

    // Remember the winner for the response and advance the RR pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            w_q       <= '0;
            id_q      <= '0;
            rr_ptr    <= '0;
        end else if (clear_i) begin
            r_valid_q <= 1'b0;
            w_q       <= '0;
            id_q      <= '0;
            rr_ptr    <= '0;
        end else begin
            r_valid_q <= hs;
            if (hs) begin
                w_q    <= win;
                id_q   <= win_id;
                rr_ptr <= (win == IDX_W'(N_IN - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Response valid goes to the channel that won the previous cycle
    always_comb begin
        bus.in_r_valid_o = '0;
        if (r_valid_q) bus.in_r_valid_o[w_q] = 1'b1;
    end

    assign bus.in_r_id_o   = id_q;
    assign bus.in_r_data_o = bus.mem_r_data_i;

`ifdef HCI_BANK_ARB_STATS_EN
    logic [31:0] grant_cnt [N_IN];
    logic [31:0] conflict_cnt;

    // Handshakes per channel and cycles with competing requesters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IN; i++) grant_cnt[i] <= '0;
            conflict_cnt <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < N_IN; i++) grant_cnt[i] <= '0;
            conflict_cnt <= '0;
        end else begin
            if (hs) grant_cnt[win] <= grant_cnt[win] + 32'd1;
            if ($countones(bus.in_req_i) >= 2)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    // Flatten the per-channel counters onto the output bus
    always_comb begin
        for (int i = 0; i < N_IN; i++)
            stat_grant_o[i*32 +: 32] = grant_cnt[i];
    end

    assign stat_conflict_o = conflict_cnt;
`else
    assign stat_grant_o    = '0;
    assign stat_conflict_o = '0;
`endif
endmodule

// File: tb/tb_hci_bank_arbiter.sv
// Bench for hci_bank_arbiter: fixed-priority and round-robin instances side by side.
// Table vectors, directed corner sequences and a random run against a queue-free reference model.
module tb_hci_bank_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int IW  = 8;
    localparam int BEW = DW / BW;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [7:0] th;
    logic [N*32-1:0] sg_fx, sg_rr;
    logic [31:0] sc_fx, sc_rr;

    always #5 clk = ~clk;

    hci_bank_arbiter_if #(.N_IN(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW)) bus_fx ();
    hci_bank_arbiter_if #(.N_IN(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW)) bus_rr ();

    hci_bank_arbiter #(.N_IN(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW),
                       .CNT_W(8), .RR_EN(0)) dut_fx (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .ctrl_max_stall_i(th), .bus(bus_fx),
        .stat_grant_o(sg_fx), .stat_conflict_o(sc_fx)
    );

    hci_bank_arbiter #(.N_IN(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW),
                       .CNT_W(8), .RR_EN(1)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .ctrl_max_stall_i(th), .bus(bus_rr),
        .stat_grant_o(sg_rr), .stat_conflict_o(sc_rr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0]    req;
    logic            mg;
    logic [AW-1:0]   p_add  [N];
    logic            p_wen  [N];
    logic [BEW-1:0]  p_be   [N];
    logic [DW-1:0]   p_data [N];
    logic [IW-1:0]   p_id   [N];
    logic [DW-1:0]   rdata;

    // reference model state: index 0 = fixed instance, 1 = round-robin
    int            wc [2][N];
    int            ptr;
    bit            pv [2];
    int            pch [2];
    logic [IW-1:0] mrid [2];
    int            sg [2][N];
    int            sc;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus_fx.in_add_i[i*AW +: AW]   = p_add[i];
            bus_rr.in_add_i[i*AW +: AW]   = p_add[i];
            bus_fx.in_wen_i[i]            = p_wen[i];
            bus_rr.in_wen_i[i]            = p_wen[i];
            bus_fx.in_be_i[i*BEW +: BEW]  = p_be[i];
            bus_rr.in_be_i[i*BEW +: BEW]  = p_be[i];
            bus_fx.in_data_i[i*DW +: DW]  = p_data[i];
            bus_rr.in_data_i[i*DW +: DW]  = p_data[i];
            bus_fx.in_id_i[i*IW +: IW]    = p_id[i];
            bus_rr.in_id_i[i*IW +: IW]    = p_id[i];
        end
        bus_fx.in_req_i     = req;
        bus_rr.in_req_i     = req;
        bus_fx.mem_gnt_i    = mg;
        bus_rr.mem_gnt_i    = mg;
        bus_fx.mem_r_data_i = rdata;
        bus_rr.mem_r_data_i = rdata;
    endtask

    // Winner from the rules: starved-lowest, else lowest; or rotating from ptr
    function automatic int winner(int m);
        if (m == 0) begin
            if (th != 0)
                for (int i = 0; i < N; i++)
                    if (req[i] && wc[0][i] >= int'(th)) return i;
            for (int i = 0; i < N; i++)
                if (req[i]) return i;
            return -1;
        end
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pv[m] = 0; pch[m] = 0; mrid[m] = '0;
            for (int i = 0; i < N; i++) begin
                wc[m][i] = 0; sg[m][i] = 0;
            end
        end
        ptr = 0; sc = 0;
    endtask

    task automatic model_step();
        int w;
        bit hs;
        if (clear) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            w  = winner(m);
            hs = (w >= 0) && mg;
            pv[m] = hs;
            if (hs) begin
                pch[m]  = w;
                mrid[m] = p_id[w];
                sg[m][w]++;
                if (m == 1) ptr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && !(hs && w == i))
                    wc[m][i] = (wc[m][i] < 255) ? wc[m][i] + 1 : 255;
                else
                    wc[m][i] = 0;
            end
        end
        if ($countones(req) >= 2) sc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_bus(string tag, int m, logic [N-1:0] gnt,
                             logic mreq, logic [AW-1:0] madd, logic mwen,
                             logic [N-1:0] rv, logic [IW-1:0] rid,
                             logic [DW-1:0] rdo);
        int w;
        logic [N-1:0] eg, erv;
        w   = winner(m);
        eg  = (w >= 0 && mg) ? N'(1 << w) : '0;
        erv = pv[m] ? N'(1 << pch[m]) : '0;
        check({tag, "_gnt"}, 128'(gnt), 128'(eg));
        check({tag, "_mem_req"}, 128'(mreq), 128'(req != 0));
        if (w >= 0) begin
            check({tag, "_mem_add"}, 128'(madd), 128'(p_add[w]));
            check({tag, "_mem_wen"}, 128'(mwen), 128'(p_wen[w]));
        end
        check({tag, "_r_valid"}, 128'(rv), 128'(erv));
        check({tag, "_r_id"}, 128'(rid), 128'(mrid[m]));
        check({tag, "_r_data"}, 128'(rdo), 128'(rdata));
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         g;
        logic [N-1:0] gfx;
        logic [N-1:0] grr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [N-1:0] prev_fx, prev_rr;
        int th_pick [5];

        th_pick = '{0, 1, 2, 3, 6};
        th = 8'd0; clear = 1'b0; req = '0; mg = 1'b1; rdata = 32'hCAFE_0000;
        for (int i = 0; i < N; i++) begin
            p_add[i]  = 32'h1000 * (i + 1);
            p_wen[i]  = 1'b1;
            p_be[i]   = 4'hF;
            p_data[i] = 32'h5000 + i;
            p_id[i]   = 8'hA0 + 8'(i);
        end
        apply();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_gnt_fx", 128'(bus_fx.in_gnt_o), 0);
        check("rst_mem_req_fx", 128'(bus_fx.mem_req_o), 0);
        check("rst_r_valid_fx", 128'(bus_fx.in_r_valid_o), 0);
        check("rst_r_id_fx", 128'(bus_fx.in_r_id_o), 0);
        check("rst_r_valid_rr", 128'(bus_rr.in_r_valid_o), 0);
        check("rst_stat_grant", 128'(sg_fx), 0);
        tick();

        // table: consecutive vectors from reset, threshold disabled
        tbl[0] = '{3'b111, 1'b1, 3'b001, 3'b001};
        tbl[1] = '{3'b111, 1'b1, 3'b001, 3'b010};
        tbl[2] = '{3'b011, 1'b1, 3'b001, 3'b001};
        tbl[3] = '{3'b101, 1'b0, 3'b000, 3'b000};
        tbl[4] = '{3'b101, 1'b1, 3'b001, 3'b100};
        tbl[5] = '{3'b000, 1'b1, 3'b000, 3'b000};
        tbl[6] = '{3'b110, 1'b1, 3'b010, 3'b010};
        tbl[7] = '{3'b010, 1'b1, 3'b010, 3'b010};
        prev_fx = '0; prev_rr = '0;
        for (int v = 0; v < 8; v++) begin
            req = tbl[v].req; mg = tbl[v].g;
            apply();
            @(negedge clk);
            check($sformatf("tbl%0d_gnt_fx", v), 128'(bus_fx.in_gnt_o), 128'(tbl[v].gfx));
            check($sformatf("tbl%0d_gnt_rr", v), 128'(bus_rr.in_gnt_o), 128'(tbl[v].grr));
            check($sformatf("tbl%0d_rv_fx", v), 128'(bus_fx.in_r_valid_o), 128'(prev_fx));
            check($sformatf("tbl%0d_rv_rr", v), 128'(bus_rr.in_r_valid_o), 128'(prev_rr));
            prev_fx = tbl[v].gfx; prev_rr = tbl[v].grr;
            tick();
        end

        // all request once: ch0 wins, response and ID next cycle
        clear = 1'b1; req = '0; mg = 1'b1; apply(); tick(); clear = 1'b0;
        p_id[0] = 8'h3C; p_id[1] = 8'h5A; p_id[2] = 8'h77;
        req = 3'b111; apply();
        @(negedge clk);
        check("one_gnt_fx", 128'(bus_fx.in_gnt_o), 128'(3'b001));
        tick();
        req = '0; apply();
        @(negedge clk);
        check("one_rv_fx", 128'(bus_fx.in_r_valid_o), 128'(3'b001));
        check("one_rid_fx", 128'(bus_fx.in_r_id_o), 128'(8'h3C));
        tick();

        // starvation escape: threshold 4, ch0 and ch2 hold requests
        clear = 1'b1; apply(); tick(); clear = 1'b0;
        th = 8'd4; req = 3'b101; apply();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("starve_c%0d", c), 128'(bus_fx.in_gnt_o),
                  128'((c % 5 == 0) ? 3'b100 : 3'b001));
            tick();
        end
        th = 8'd0; req = '0; apply(); tick();

        // bank stall: no grant for 3 cycles, then grant, then response
        clear = 1'b1; apply(); tick(); clear = 1'b0;
        req = 3'b010; mg = 1'b0; apply();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_fx_c%0d", c), 128'(bus_fx.in_gnt_o), 0);
            check($sformatf("stall_rr_c%0d", c), 128'(bus_rr.in_gnt_o), 0);
            tick();
        end
        mg = 1'b1; apply();
        @(negedge clk);
        check("stall_gnt_fx", 128'(bus_fx.in_gnt_o), 128'(3'b010));
        check("stall_gnt_rr", 128'(bus_rr.in_gnt_o), 128'(3'b010));
        tick();
        req = '0; apply();
        @(negedge clk);
        check("stall_rv_fx", 128'(bus_fx.in_r_valid_o), 128'(3'b010));
        check("stall_rv_rr", 128'(bus_rr.in_r_valid_o), 128'(3'b010));
        tick();

        // reset right after a read handshake drops the response
        req = 3'b010; mg = 1'b1; p_wen[1] = 1'b1; apply();
        @(negedge clk);
        check("rstmid_gnt_fx", 128'(bus_fx.in_gnt_o), 128'(3'b010));
        tick();
        req = '0; apply();
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        check("rstmid_rv_fx", 128'(bus_fx.in_r_valid_o), 0);
        check("rstmid_rv_rr", 128'(bus_rr.in_r_valid_o), 0);
        check("rstmid_stat_fx", 128'(sg_fx), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_rv_after", 128'(bus_fx.in_r_valid_o), 0);
        check("rstmid_rid_after", 128'(bus_fx.in_r_id_o), 0);
        tick();

        // statistics over 10 all-request cycles
        clear = 1'b1; apply(); tick(); clear = 1'b0;
        req = 3'b111; mg = 1'b1; apply();
        repeat (10) tick();
        req = '0; apply();
        @(negedge clk);
`ifdef HCI_BANK_ARB_STATS_EN
        check("stat_grant_rr", 128'(sg_rr), 128'({32'd3, 32'd3, 32'd4}));
        check("stat_conflict_rr", 128'(sc_rr), 128'(32'd10));
        check("stat_grant_fx", 128'(sg_fx), 128'({32'd0, 32'd0, 32'd10}));
        check("stat_conflict_fx", 128'(sc_fx), 128'(32'd10));
`else
        check("stat_grant_rr", 128'(sg_rr), 0);
        check("stat_conflict_rr", 128'(sc_rr), 0);
`endif
        tick();

        // random traffic against the reference model
        clear = 1'b1; apply(); tick(); clear = 1'b0;
        for (int n = 0; n < 400; n++) begin
            req   = N'($urandom_range(0, 7));
            mg    = ($urandom_range(0, 9) < 8);
            th    = 8'(th_pick[$urandom_range(0, 4)]);
            clear = ($urandom_range(0, 49) == 0);
            rdata = $urandom;
            for (int i = 0; i < N; i++) begin
                p_add[i]  = $urandom;
                p_wen[i]  = 1'($urandom_range(0, 1));
                p_be[i]   = 4'($urandom_range(0, 15));
                p_data[i] = $urandom;
                p_id[i]   = 8'($urandom_range(0, 255));
            end
            apply();
            @(negedge clk);
            check_bus("rnd_fx", 0, bus_fx.in_gnt_o, bus_fx.mem_req_o,
                      bus_fx.mem_add_o, bus_fx.mem_wen_o, bus_fx.in_r_valid_o,
                      bus_fx.in_r_id_o, bus_fx.in_r_data_o);
            check_bus("rnd_rr", 1, bus_rr.in_gnt_o, bus_rr.mem_req_o,
                      bus_rr.mem_add_o, bus_rr.mem_wen_o, bus_rr.in_r_valid_o,
                      bus_rr.in_r_id_o, bus_rr.in_r_data_o);
`ifdef HCI_BANK_ARB_STATS_EN
            for (int i = 0; i < N; i++) begin
                check("rnd_sg_fx", 128'(sg_fx[i*32 +: 32]), 128'(32'(sg[0][i])));
                check("rnd_sg_rr", 128'(sg_rr[i*32 +: 32]), 128'(32'(sg[1][i])));
            end
            check("rnd_sc_fx", 128'(sc_fx), 128'(32'(sc)));
`endif
            tick();
        end
        clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hci_bank_arbiter.md
Name: hci_bank_arbiter

Overview:
Per-bank N-way arbiter and response router. It is the generalised successor of the fixed two-level high/low priority merge in front of each TCDM bank. It takes N_IN requestor channels (index 0 highest static priority; typically log-interconnect, HWPE and extra accelerator ports), forwards one request per cycle to a single-ported SRAM bank, and routes the 1-cycle-latency response back to the winner. A per-channel starvation counter with a runtime threshold guarantees forward progress for low-priority channels.

Parameters:
N_IN, 3, number of requestor channels (>=2)
AW, 32, address width
DW, 32, data width
BW, 8, byte width; BE width = DW/BW
IW, 8, request ID width
CNT_W, 8, starvation counter width
RR_EN, 0, 0 = fixed priority plus starvation escape; 1 = pure round-robin (threshold ignored)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
clear_i  in  1  sync clear of all state
ctrl_max_stall_i  in  CNT_W  starvation threshold; 0 disables escape
in_req_i  in  N_IN  request per channel
in_gnt_o  out  N_IN  grant per channel
in_add_i  in  N_IN*AW  address
in_wen_i  in  N_IN  1 = read, 0 = write
in_be_i  in  N_IN*DW/BW  byte enable
in_data_i  in  N_IN*DW  write data
in_id_i  in  N_IN*IW  request ID
in_r_valid_o  out  N_IN  response valid
in_r_data_o  out  DW  response data, shared bus
in_r_id_o  out  IW  response ID
mem_req_o  out  1  bank request
mem_gnt_i  in  1  bank grant
mem_add_o  out  AW  bank address
mem_wen_o  out  1  bank read/write
mem_be_o  out  DW/BW  bank byte enable
mem_data_o  out  DW  bank write data
mem_r_data_i  in  DW  bank read data, valid 1 cycle after a granted handshake
stat_grant_o  out  N_IN*32  per-channel grant counters (optional feature)
stat_conflict_o  out  32  conflict-cycle counter (optional feature)

Behaviour:
- Reset (rst_ni low, asynchronous): in_r_valid_o=0, in_r_id_o=0, starvation counters=0, RR pointer=0, response-index register=0. in_gnt_o and mem_req_o are combinational and are 0 whenever in_req_i=0.
- clear_i=1 has the same effect as reset, applied on the next clock edge.
- Arbitration is combinational within the cycle:
  - mem_req_o = |in_req_i.
  - Winner w is selected and its add/wen/be/data are muxed to mem_*.
  - in_gnt_o[w] = mem_gnt_i. All other grant bits are 0.
- Fixed mode (RR_EN=0):
  - w is the lowest-index requester.
  - Exception: if any channel has stall_cnt[i] >= ctrl_max_stall_i with ctrl_max_stall_i != 0, w is the lowest such i.
- Starvation counter, per cycle:
  - Counter i increments (saturating at 2^CNT_W-1) when in_req_i[i]=1 and in_gnt_o[i]=0.
  - It resets to 0 when in_gnt_o[i]=1 or in_req_i[i]=0.
- RR mode (RR_EN=1):
  - w is the first requester at or after the pointer, searching with wrap-around.
  - On a handshake, the pointer becomes (w+1) mod N_IN.
  - Without a handshake, the pointer holds.
- Handshake = mem_req_o & mem_gnt_i. On a handshake, register w and in_id_i[w].
- Response (1-cycle latency, reads and writes alike):
  - The cycle after a handshake, in_r_valid_o[w_reg]=1 and in_r_id_o = id_reg.
  - in_r_data_o = mem_r_data_i combinationally; it is meaningful only for reads.
  - Otherwise in_r_valid_o = 0.
- Back-to-back handshakes give one response per cycle. There is no buffering; requesters must accept the response unconditionally.
- mem_gnt_i=0 while requests are pending:
  - No grant is issued.
  - Counters of all requesters increment.
  - The RR pointer holds.
- Reset asserted mid-transaction drops the in-flight response; no r_valid is issued after reset.
- A threshold change takes effect on the same cycle.

Optional Feature:
HCI_BANK_ARB_STATS_EN:
- Defined:
  - stat_grant_o[i] is a 32-bit wrapping counter of handshakes won by channel i.
  - stat_conflict_o counts cycles where popcount(in_req_i) >= 2.
  - Both are cleared by reset and by clear_i.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- N_IN=3, RR_EN=0, mem_gnt_i=1; in_req_i=3'b111 for one cycle -> in_gnt_o=3'b001. Next cycle: in_r_valid_o=3'b001 and in_r_id_o equals ch0's ID.
- ctrl_max_stall_i=4; ch0 and ch2 request continuously -> ch2 is granted on cycle 5 (counter reached 4), ch0 on all other cycles; the pattern repeats every 5 cycles.
- RR_EN=1; all 3 channels request continuously -> grant sequence 0,1,2,0,1,2.
- mem_gnt_i=0 for 3 cycles with ch1 requesting, then 1 -> no gnt during stall; gnt on cycle 4; r_valid on cycle 5.
- Read handshake to ch1 with rst_ni pulsed low in the following cycle -> in_r_valid_o stays 0 and counters read 0.
- With HCI_BANK_ARB_STATS_EN: 10 cycles with all 3 channels requesting and mem_gnt_i=1, RR_EN=1 -> stat_grant_o = {3,3,4} for ch2,ch1,ch0 and stat_conflict_o=10.
